quad_decoder: RTL and testbench

//   Quadrature (A/B) input decoder for the sequential_design counter family.

---
 rtl/quad_decoder_pkg.sv | 33 +++
 rtl/quad_decoder_if.sv | 26 ++
 rtl/quad_filter.sv | 65 ++++++
 rtl/quad_decoder.sv | 94 +++++++++
 tb/tb_quad_decoder.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/quad_decoder_pkg.sv
// Shared definitions for the quadrature decoder: step command codes, phase type,
// FSM state encoding and the Gray-order decode helper.
package quad_decoder_pkg;

   typedef logic [1:0] ctrl_t;
   typedef logic [1:0] phase_t;

   // Same codes as the up/down counter's step input
   localparam ctrl_t CTRL_HOLD = 2'b00;
   localparam ctrl_t CTRL_INC  = 2'b01;
   localparam ctrl_t CTRL_DEC  = 2'b10;

   localparam logic [1:0] DELTA_NONE = 2'd0;
   localparam logic [1:0] DELTA_FWD  = 2'd1;
   localparam logic [1:0] DELTA_BAD  = 2'd2;
   localparam logic [1:0] DELTA_REV  = 2'd3;

   typedef enum logic {
      INIT  = 1'b0,
      TRACK = 1'b1
   } state_t;

   // Position of a phase along 00->01->11->10 (binary of the Gray code)
   function automatic logic [1:0] gray_pos(input phase_t ph);
      return {ph[1], ph[1] ^ ph[0]};
   endfunction

   // Modulo-4 distance travelled from old_ph to new_ph
   function automatic logic [1:0] gray_delta(input phase_t old_ph, input phase_t new_ph);
      return gray_pos(new_ph) - gray_pos(old_ph);
   endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder-side bundle of the quadrature decoder: raw A/B lines and controls in,
// step command, position and error flag out.
interface quad_decoder_if #(
   parameter int W = 8
);
   import quad_decoder_pkg::*;

   logic         a_in;
   logic         b_in;
   logic         en;
   logic         err_clr;
   ctrl_t        ctrl;
   logic [W-1:0] count;
   logic         err;

   modport master (
      output a_in, b_in, en, err_clr,
      input  ctrl, count, err
   );

   modport slave (
      input  a_in, b_in, en, err_clr,
      output ctrl, count, err
   );

endinterface

// File: rtl/quad_filter.sv
// Two-flop synchronizer for the A/B pair followed by a stability filter that
// only passes a new pair once it has been seen on FILT consecutive edges.
module quad_filter
   import quad_decoder_pkg::*;
#(
   parameter int FILT = 2
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   a_raw,
   input  logic   b_raw,
   output phase_t filt,
   output logic   filt_valid
);

   localparam int CW = $clog2(FILT + 1);

   phase_t        sync1_reg;
   phase_t        sync2_reg;
   phase_t        last_reg;
   phase_t        filt_reg;
   logic [1:0]    prime_reg;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          valid_reg;

   // Samples are ignored until the synchronizer holds real input, so the
   // cleared flops are never mistaken for a settled phase after reset.
   always_comb begin
      cnt_next = cnt_reg;
      if (!prime_reg[1]) begin
         cnt_next = '0;
      end else if ((cnt_reg == '0) || (sync2_reg != last_reg)) begin
         cnt_next = CW'(1);
      end else if (cnt_reg < CW'(FILT)) begin
         cnt_next = cnt_reg + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         last_reg  <= '0;
         filt_reg  <= '0;
         prime_reg <= '0;
         cnt_reg   <= '0;
         valid_reg <= 1'b0;
      end else begin
         sync1_reg <= {a_raw, b_raw};
         sync2_reg <= sync1_reg;
         prime_reg <= {prime_reg[0], 1'b1};
         last_reg  <= sync2_reg;
         cnt_reg   <= cnt_next;
         if (prime_reg[1] && (cnt_next == CW'(FILT))) begin
            filt_reg  <= sync2_reg;
            valid_reg <= 1'b1;
         end
      end
   end

   assign filt       = filt_reg;
   assign filt_valid = valid_reg;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder top: filters the A/B lines, decodes Gray-order phase changes
// into one-cycle up/down step pulses, tracks position and flags illegal jumps.
module quad_decoder
   import quad_decoder_pkg::*;
#(
   parameter int W    = 8,
   parameter int FILT = 2
) (
   input  logic           clk,
   input  logic           rst,
   quad_decoder_if.slave  bus
);

   phase_t       filt;
   logic         filt_valid;

   state_t       state_reg, state_next;
   phase_t       ref_reg, ref_next;
   ctrl_t        ctrl_reg, ctrl_next;
   logic [W-1:0] count_reg, count_next;
   logic         err_reg, err_next;

   quad_filter #(
      .FILT (FILT)
   ) u_filter (
      .clk        (clk),
      .rst        (rst),
      .a_raw      (bus.a_in),
      .b_raw      (bus.b_in),
      .filt       (filt),
      .filt_valid (filt_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= INIT;
         ref_reg   <= '0;
         ctrl_reg  <= CTRL_HOLD;
         count_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         ref_reg   <= ref_next;
         ctrl_reg  <= ctrl_next;
         count_reg <= count_next;
         err_reg   <= err_next;
      end
   end

   // Phase tracking and error detection run regardless of en; en only gates
   // the step pulse and the position update.
   always_comb begin
      state_next = state_reg;
      ref_next   = ref_reg;
      ctrl_next  = CTRL_HOLD;
      count_next = count_reg;
      err_next   = err_reg & ~bus.err_clr;
      case (state_reg)
         INIT: begin
            if (filt_valid) begin
               ref_next   = filt;
               state_next = TRACK;
            end
         end
         TRACK: begin
            if (filt != ref_reg) begin
               ref_next = filt;
               case (gray_delta(ref_reg, filt))
                  DELTA_FWD: begin
                     if (bus.en) begin
                        ctrl_next  = CTRL_INC;
                        count_next = count_reg + 1'b1;
                     end
                  end
                  DELTA_REV: begin
                     if (bus.en) begin
                        ctrl_next  = CTRL_DEC;
                        count_next = count_reg - 1'b1;
                     end
                  end
                  DELTA_BAD: err_next = 1'b1;
                  default: ;
               endcase
            end
         end
         default: state_next = INIT;
      endcase
   end

   assign bus.ctrl  = ctrl_reg;
   assign bus.count = count_reg;
   assign bus.err   = err_reg;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (W=8, FILT=2): phase steps, wrap, glitch,
// illegal transitions with err_clr, enable gating and mid-step reset.
module tb_quad_decoder;
   import quad_decoder_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   quad_decoder_if #(.W(8)) bus ();

   quad_decoder #(
      .W    (8),
      .FILT (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a new A/B level at a negedge; the following posedge is e0. The pulse
   // must be absent after e3, present after e4 and gone again after e5.
   task automatic step(input string tag, input logic [1:0] ab, input logic clr_at_e4,
                       input ctrl_t exp_ctrl, input logic [7:0] exp_count);
      @(negedge clk);
      bus.a_in = ab[1];
      bus.b_in = ab[0];
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         if (k == 3) begin
            check({tag, "_early"}, 32'(bus.ctrl), 32'(CTRL_HOLD));
            bus.err_clr = clr_at_e4;
         end
      end
      bus.err_clr = 1'b0;
      $display("step %s ab=%b ctrl=%b count=%0d err=%b", tag, ab, bus.ctrl, bus.count, bus.err);
      check({tag, "_ctrl"}, 32'(bus.ctrl), 32'(exp_ctrl));
      check({tag, "_count"}, 32'(bus.count), 32'(exp_count));
      @(posedge clk);
      #1;
      check({tag, "_pulse_end"}, 32'(bus.ctrl), 32'(CTRL_HOLD));
      repeat (2) @(posedge clk);
   endtask

   task automatic do_reset(input logic [1:0] ab);
      @(negedge clk);
      rst      = 1'b1;
      bus.a_in = ab[1];
      bus.b_in = ab[0];
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Watches ctrl for n cycles; returns 1 if any non-hold value appeared
   task automatic watch(input int n, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (bus.ctrl !== CTRL_HOLD) seen = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic seen;
      rst         = 1'b1;
      bus.a_in    = 1'b1;
      bus.b_in    = 1'b1;
      bus.en      = 1'b1;
      bus.err_clr = 1'b0;

      // 1: hold 11 through reset
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", 32'(bus.ctrl), 32'(CTRL_HOLD));
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      watch(10, seen);
      $display("init phase=11 pulse_seen=%b count=%0d err=%b", seen, bus.count, bus.err);
      check("init_no_pulse", 32'(seen), 32'd0);
      check("init_count", 32'(bus.count), 32'd0);
      check("init_err", 32'(bus.err), 32'd0);
      // Reference 11 means 11->10->00 are forward steps
      step("ref_fwd1", 2'b10, 1'b0, CTRL_INC, 8'd1);
      step("ref_fwd2", 2'b00, 1'b0, CTRL_INC, 8'd2);
      check("ref_err", 32'(bus.err), 32'd0);

      // 2: four forward steps from 00
      do_reset(2'b00);
      repeat (8) @(posedge clk);
      step("fwd1", 2'b01, 1'b0, CTRL_INC, 8'd1);
      step("fwd2", 2'b11, 1'b0, CTRL_INC, 8'd2);
      step("fwd3", 2'b10, 1'b0, CTRL_INC, 8'd3);
      step("fwd4", 2'b00, 1'b0, CTRL_INC, 8'd4);

      // 3: reverse from 0 wraps to 255, forward wraps back to 0
      do_reset(2'b00);
      repeat (8) @(posedge clk);
      step("rev_wrap", 2'b10, 1'b0, CTRL_DEC, 8'd255);
      step("fwd_wrap", 2'b00, 1'b0, CTRL_INC, 8'd0);

      // 4: one-cycle glitch on A
      @(negedge clk);
      bus.a_in = 1'b1;
      @(negedge clk);
      bus.a_in = 1'b0;
      watch(8, seen);
      $display("glitch pulse_seen=%b count=%0d err=%b", seen, bus.count, bus.err);
      check("glitch_no_pulse", 32'(seen), 32'd0);
      check("glitch_count", 32'(bus.count), 32'd0);
      check("glitch_err", 32'(bus.err), 32'd0);

      // 5: illegal double-bit changes and err_clr priority
      step("ill1", 2'b11, 1'b0, CTRL_HOLD, 8'd0);
      check("ill1_err", 32'(bus.err), 32'd1);
      step("ill2_clr", 2'b00, 1'b1, CTRL_HOLD, 8'd0);
      check("ill2_err_set_wins", 32'(bus.err), 32'd1);
      @(negedge clk);
      bus.err_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.err_clr = 1'b0;
      $display("err_clr alone err=%b", bus.err);
      check("clr_err", 32'(bus.err), 32'd0);

      // 6: steps with en=0 are dropped, then one enabled step
      bus.en = 1'b0;
      step("dis1", 2'b01, 1'b0, CTRL_HOLD, 8'd0);
      step("dis2", 2'b11, 1'b0, CTRL_HOLD, 8'd0);
      step("dis3", 2'b10, 1'b0, CTRL_HOLD, 8'd0);
      bus.en = 1'b1;
      step("en_fwd", 2'b00, 1'b0, CTRL_INC, 8'd1);
      check("en_err", 32'(bus.err), 32'd0);

      // Reset lands on the edge that would have issued the pulse
      @(negedge clk);
      bus.a_in = 1'b0;
      bus.b_in = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      $display("mid-step reset ctrl=%b count=%0d err=%b", bus.ctrl, bus.count, bus.err);
      check("midrst_ctrl", 32'(bus.ctrl), 32'(CTRL_HOLD));
      check("midrst_count", 32'(bus.count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      watch(10, seen);
      check("post_rst_no_pulse", 32'(seen), 32'd0);
      check("post_rst_count", 32'(bus.count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
